// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, gates fetched words to decode, detects halt, redirects on branches.
// Define FETCH_LUT_EN for LUT-indexed branch targets; otherwise BrSel is a signed PC offset.
module fetch_ctrl #(
    parameter int            PC_W      = 8,
    parameter int            IW        = 9,
    parameter int            LUT_DEPTH = 16,
    parameter logic [IW-1:0] HALT_WORD = 9'b011111111,
    localparam int           LW        = $clog2(LUT_DEPTH)
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Req,
    input  logic            Stall,
    input  logic            BrTaken,
    input  logic [LW-1:0]   BrSel,
    input  logic            LutWe,
    input  logic [LW-1:0]   LutIdx,
    input  logic [PC_W-1:0] LutData,
    input  logic [IW-1:0]   Instr,
    output logic [PC_W-1:0] ProgCtr,
    output logic [IW-1:0]   InstrOut,
    output logic            InstrValid,
    output logic            Done,
    output logic [15:0]     CycleCnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]     CNT_ONE = 16'd1;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            done_q, done_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [PC_W-1:0] br_tgt;
    logic            run;

    assign run = (state_q == S_RUN);

`ifdef FETCH_LUT_EN
    logic [PC_W-1:0] lut_q [LUT_DEPTH];
    logic [PC_W-1:0] lut_d [LUT_DEPTH];

    // Branch reads the pre-edge entry, so a same-cycle write never bypasses.
    assign br_tgt = lut_q[BrSel];

    always_comb begin
        lut_d = lut_q;
        if (LutWe) begin
            lut_d[LutIdx] = LutData;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            lut_q <= lut_d;
        end
    end
`else
    logic unused_lut;

    assign unused_lut = ^{LutWe, LutIdx, LutData};
    assign br_tgt     = pc_q + {{(PC_W-LW){BrSel[LW-1]}}, BrSel};
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (Req) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (!Stall) begin
                    if (Instr == HALT_WORD) begin
                        state_d = S_HALT;
                        done_d  = 1'b1;
                    end else if (BrTaken) begin
                        pc_d = br_tgt;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
            end
            S_HALT: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ProgCtr    = pc_q;
    assign InstrOut   = run ? Instr : '0;
    assign InstrValid = run && !Stall;
    assign Done       = done_q;
    assign CycleCnt   = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed plan scenarios plus random traffic against a cycle-level model.
// Model keeps state as plain integers; instruction memory lives in the bench.
module tb_fetch_ctrl;

    localparam int HALT = 9'h0FF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic       stall;
    logic       br_taken;
    logic [3:0] br_sel;
    logic       lut_we;
    logic [3:0] lut_idx;
    logic [7:0] lut_data;
    logic [8:0] instr;
    logic [7:0] prog_ctr;
    logic [8:0] instr_out;
    logic       instr_valid;
    logic       done;
    logic [15:0] cycle_cnt;

    logic [8:0] mem [256];

    int total = 0;
    int bad   = 0;

    int m_state;
    int m_pc;
    int m_done;
    int m_cnt;
    int m_lut [16];

    always #5 clk = ~clk;

    assign instr = mem[prog_ctr];

    fetch_ctrl dut (
        .Clk        (clk),
        .Reset      (rst_n),
        .Req        (req),
        .Stall      (stall),
        .BrTaken    (br_taken),
        .BrSel      (br_sel),
        .LutWe      (lut_we),
        .LutIdx     (lut_idx),
        .LutData    (lut_data),
        .Instr      (instr),
        .ProgCtr    (prog_ctr),
        .InstrOut   (instr_out),
        .InstrValid (instr_valid),
        .Done       (done),
        .CycleCnt   (cycle_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 run, 2 halt.
    task automatic step_model(input bit rs, input bit rq, input bit st,
                              input bit br, input int sel, input bit we,
                              input int idx, input int data);
        int off;
        if (!rs) begin
            m_state = 0;
            m_pc    = 0;
            m_done  = 0;
            m_cnt   = 0;
            for (int i = 0; i < 16; i++) m_lut[i] = 0;
            return;
        end
        if (m_state == 0) begin
            if (rq) m_state = 1;
        end else if (m_state == 1) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (!st) begin
                if (int'(mem[m_pc]) == HALT) begin
                    m_state = 2;
                    m_done  = 1;
                end else if (br) begin
`ifdef FETCH_LUT_EN
                    m_pc = m_lut[sel];
`else
                    off  = (sel >= 8) ? sel - 16 : sel;
                    m_pc = (m_pc + off) & 255;
`endif
                end else begin
                    m_pc = (m_pc + 1) % 256;
                end
            end
        end
`ifdef FETCH_LUT_EN
        if (we) m_lut[idx] = data;
`endif
    endtask

    task automatic cyc(input bit rs = 1, input bit rq = 0, input bit st = 0,
                       input bit br = 0, input int sel = 0, input bit we = 0,
                       input int idx = 0, input int data = 0);
        @(negedge clk);
        rst_n    = rs;
        req      = rq;
        stall    = st;
        br_taken = br;
        br_sel   = sel[3:0];
        lut_we   = we;
        lut_idx  = idx[3:0];
        lut_data = data[7:0];
        #1;
        check("pc", prog_ctr, m_pc);
        check("valid", instr_valid, (m_state == 1) && !st);
        check("iout", instr_out, (m_state == 1) ? mem[m_pc] : 0);
        check("done", done, m_done);
        check("cnt", cycle_cnt, m_cnt);
        @(posedge clk);
        step_model(rs, rq, st, br, sel, we, idx, data);
    endtask

    task automatic load_straight();
        for (int i = 0; i < 256; i++) mem[i] = 9'd0;
        for (int i = 0; i < 4; i++) mem[i] = 9'(i);
        mem[4]    = 9'(HALT);
        mem[8'h20] = 9'd1;
    endtask

    task automatic do_reset();
        cyc(0);
        cyc(0);
    endtask

    initial begin
        rst_n = 0; req = 0; stall = 0; br_taken = 0; br_sel = 0;
        lut_we = 0; lut_idx = 0; lut_data = 0;
        m_state = 0; m_pc = 0; m_done = 0; m_cnt = 0;
        for (int i = 0; i < 16; i++) m_lut[i] = 0;
        load_straight();

        // Reset state and straight-line program
        do_reset();
        #2;
        check("rst_pc", prog_ctr, 0);
        check("rst_done", done, 0);
        check("rst_cnt", cycle_cnt, 0);
        cyc(1, 1);
        repeat (5) cyc();
        #2;
        check("sl_done", done, 1);
        check("sl_cnt", cycle_cnt, 5);
        check("sl_pc", prog_ctr, 4);
        repeat (2) cyc();
        #2;
        check("sl_pc_hold", prog_ctr, 4);
        check("sl_cnt_hold", cycle_cnt, 5);

        // Stall two cycles at PC 2
        do_reset();
        cyc(1, 1);
        cyc();
        cyc();
        #2;
        check("st_at2", prog_ctr, 2);
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        #2;
        check("st_hold", prog_ctr, 2);
        repeat (2) cyc();
        #2;
        check("st_not_done", done, 0);
        cyc();
        #2;
        check("st_done", done, 1);
        check("st_cnt", cycle_cnt, 7);

`ifdef FETCH_LUT_EN
        // LUT branch with same-cycle write collision
        do_reset();
        cyc(1, 0, 0, 0, 0, 1, 3, 8'h20);
        cyc(1, 1);
        cyc();
        cyc(1, 0, 0, 1, 3, 1, 3, 8'h40);
        #2;
        check("lut_br_old", prog_ctr, 8'h20);
        cyc(1, 0, 0, 1, 3);
        #2;
        check("lut_br_new", prog_ctr, 8'h40);
`else
        // Negative offset branch wraps below zero, then increment wraps up
        do_reset();
        cyc(1, 1);
        cyc();
        cyc(1, 0, 0, 1, 4'hE);
        #2;
        check("off_wrap", prog_ctr, 8'hFF);
        cyc();
        #2;
        check("inc_wrap", prog_ctr, 8'h00);
`endif

        // Reset mid-run, then halt ignores Req
        do_reset();
`ifdef FETCH_LUT_EN
        cyc(1, 0, 0, 0, 0, 1, 3, 8'h55);
`endif
        cyc(1, 1);
        repeat (3) cyc();
        #2;
        check("mr_at3", prog_ctr, 3);
        cyc(0);
        #2;
        check("mr_pc", prog_ctr, 0);
        check("mr_done", done, 0);
        check("mr_cnt", cycle_cnt, 0);
        cyc(1, 1);
`ifdef FETCH_LUT_EN
        cyc(1, 1, 0, 1, 3);
        #2;
        check("mr_lut0", prog_ctr, 0);
`endif
        repeat (8) cyc(1, 1);
        #2;
        check("hlt_done", done, 1);
        check("hlt_pc", prog_ctr, 4);

        // Random traffic
        for (int i = 0; i < 256; i++) begin
            mem[i] = 9'($urandom % 512);
            if (int'(mem[i]) == HALT) mem[i] = 9'd0;
        end
        for (int k = 0; k < 3; k++) mem[$urandom % 256] = 9'(HALT);
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom % 80) != 0, ($urandom % 3) == 0,
                ($urandom % 4) == 0, ($urandom % 5) == 0,
                int'($urandom % 16), ($urandom % 4) == 0,
                int'($urandom % 16), int'($urandom % 256));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller sitting directly upstream of the core datapath: it owns the program counter, addresses the instruction memory, forwards each 9-bit machine word to decode, and raises `Done` when the halt word is fetched. It also holds a small writable branch-target lookup table and a run-cycle counter. Top-level benches start a program with `Req` and wait on `Done`.

## Interface
- `PC_W`, 8: program counter width; instruction memory depth is 2^PC_W.
- `IW`, 9: instruction word width.
- `LUT_DEPTH`, 16: branch-target LUT entries; index width is log2(LUT_DEPTH).
- `HALT_WORD`, 9'b011111111: machine word that ends a program.
- `Clk` in 1: the single clock; all state changes on its rising edge.
- `Reset` in 1: synchronous, active-low.
- `Req` in 1: start request; sampled in IDLE.
- `Stall` in 1: hold PC and suppress `InstrValid` this cycle.
- `BrTaken` in 1: datapath asserts for a taken branch/jump on the current instruction.
- `BrSel` in log2(LUT_DEPTH): LUT index, or signed offset (see Configuration).
- `LutWe` in 1, `LutIdx` in log2(LUT_DEPTH), `LutData` in PC_W: LUT write port.
- `Instr` in IW: instruction memory read data; combinational from `ProgCtr`.
- `ProgCtr` out PC_W: instruction memory address.
- `InstrOut` out IW: word forwarded to decode.
- `InstrValid` out 1: `InstrOut` is live this cycle.
- `Done` out 1: program has halted.
- `CycleCnt` out 16: RUN cycles elapsed.

## Operation
- States: IDLE, RUN, HALT.
- Reset (`Reset` = 0 at an edge): state IDLE, `ProgCtr` 0, `Done` 0, `CycleCnt` 0, all LUT entries 0. `InstrOut` = 0 and `InstrValid` = 0 outside RUN.
- IDLE: `Req` = 1 → RUN. `ProgCtr` stays 0.
- RUN: `InstrOut` = `Instr`. `InstrValid` = !`Stall`.
- RUN with `Stall` = 1: PC holds; no state change; `CycleCnt` still increments.
- RUN with `Stall` = 0 and `Instr` == HALT_WORD: → HALT, PC holds, `Done` set. `BrTaken` is ignored.
- RUN, not stalled, `BrTaken` = 1: PC ← branch target.
- RUN otherwise: PC ← PC+1, modulo 2^PC_W. Wrap from all-ones to 0 is legal and silent.
- HALT: PC frozen, `Done` held at 1. `Req` is ignored. Exit only through `Reset`.
- LUT write: a write with `LutWe` = 1 takes effect at the edge in any state. If a branch in the same cycle selects the written index, the branch uses the old entry.
- `CycleCnt` increments every RUN cycle, saturates at 16'hFFFF, and holds in IDLE and HALT.
- `Reset` asserted mid-RUN aborts the program and applies reset values at that edge. LUT contents are also cleared.

## Timing
- Fetch latency is 0: `InstrOut` follows `ProgCtr` combinationally within the cycle.
- PC redirect (branch, increment, or halt hold) is visible the cycle after the decision edge. There are no delay slots.
- `Done` rises on the edge that consumes HALT_WORD. It is high from the next cycle, and `InstrValid` is 0 from that cycle.
- IDLE→RUN takes one edge. The first valid instruction (address 0) is presented in the cycle after `Req` is sampled.

## Configuration
- `FETCH_LUT_EN` defined: branch target = LUT[`BrSel`]; the LUT and its write port are active.
- `FETCH_LUT_EN` undefined: no LUT storage. `LutWe`, `LutIdx` and `LutData` are ignored. Branch target = PC + sign-extended `BrSel`, modulo 2^PC_W.

## Test plan
- Straight line: memory holds words 0..3 and HALT_WORD at address 4; pulse `Req`. Required: `InstrValid` on 5 consecutive cycles with `ProgCtr` 0,1,2,3,4; `Done` = 1 on the next cycle; `CycleCnt` = 5; PC stays at 4.
- Stall: assert `Stall` for 2 cycles at PC 2. Required: PC holds at 2 for 2 cycles with `InstrValid` = 0; `Done` arrives 2 cycles later than without the stall; `CycleCnt` = 7.
- LUT branch (`FETCH_LUT_EN`): write LUT[3] = 8'h20, then at PC 1 drive `BrTaken` = 1 with `BrSel` = 3. Required: next `ProgCtr` = 8'h20.
- LUT write collision: write LUT[3] = 8'h40 in the same cycle as the branch. Required: branch goes to 8'h20; a later branch through index 3 goes to 8'h40.
- Offset branch (macro undefined): at PC 1, `BrSel` = 4'hE (−2). Required: next PC = 8'hFF (wrap). PC+1 from 8'hFF = 8'h00.
- Reset mid-run: drive `Reset` low at PC 3. Required: next cycle state IDLE, `ProgCtr` 0, `Done` 0, `CycleCnt` 0, LUT reads 0. A later HALT fetch is still ignored while in HALT even if `Req` = 1.
